// File: rtl/ace_bus_pkg.sv
// Shared types and default region map for the ACE bus controller.
// Region 0 sits in the LSBs of every packed parameter.
package ace_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONTEND,
        WSTATE,
        ACTIVE
    } state_t;

    localparam int CNT_W = 10;
    localparam int DEF_NREG = 6;
    localparam int DEF_TIMEOUT = 1023;

    localparam logic [95:0] DEF_BASE = {
        16'h8000, 16'h4000, 16'h3C00,
        16'h2C00, 16'h2400, 16'h0000
    };
    localparam logic [95:0] DEF_MASK = {
        16'h8000, 16'hC000, 16'hFC00,
        16'hFC00, 16'hFC00, 16'hE000
    };
    localparam logic [23:0] DEF_WS = {
        4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0
    };
    localparam logic [5:0] DEF_CONTEND = 6'b000110;
    localparam logic [5:0] DEF_RO = 6'b000001;

    function automatic logic is_strobe(
        input logic mreq_n,
        input logic rd_n,
        input logic wr_n
    );
        return !mreq_n && (!rd_n || !wr_n);
    endfunction

endpackage

// File: rtl/ace_bus_if.sv
// CPU/memory side signals of the ACE bus controller.
// master drives the CPU strobes and region data; slave is the controller.
interface ace_bus_if #(
    parameter int NREG = 6
);
    logic [15:0]       cpu_addr;
    logic              mreq_n;
    logic              rd_n;
    logic              wr_n;
    logic              video_active;
    logic [NREG*8-1:0] region_dout;
    logic [NREG-1:0]   region_ce;
    logic              mem_we;
    logic [7:0]        data_to_cpu;
    logic              wait_n;
    logic [2:0]        sel_idx;
    logic              hit;
    logic              timeout_flag;

    modport master (
        output cpu_addr, mreq_n, rd_n, wr_n,
        output video_active, region_dout,
        input  region_ce, mem_we, data_to_cpu,
        input  wait_n, sel_idx, hit, timeout_flag
    );

    modport slave (
        input  cpu_addr, mreq_n, rd_n, wr_n,
        input  video_active, region_dout,
        output region_ce, mem_we, data_to_cpu,
        output wait_n, sel_idx, hit, timeout_flag
    );
endinterface

// File: rtl/ace_region_decode.sv
// Priority address decoder: lowest matching region index wins.
module ace_region_decode
    import ace_bus_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter logic [NREG*16-1:0] REG_BASE = DEF_BASE,
    parameter logic [NREG*16-1:0] REG_MASK = DEF_MASK
) (
    input  logic [15:0] addr,
    output logic        hit,
    output logic [2:0]  idx
);

    always_comb begin
        hit = 1'b0;
        idx = 3'd0;
        // Walk downwards so the lowest match is the last one written.
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((addr & REG_MASK[16*i +: 16]) == REG_BASE[16*i +: 16]) begin
                hit = 1'b1;
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/ace_bus_ctrl.sv
// CPU memory bus controller: region decode, video contention,
// fixed wait states and chip-enable / write-strobe generation.
module ace_bus_ctrl
    import ace_bus_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter logic [NREG*16-1:0] REG_BASE = DEF_BASE,
    parameter logic [NREG*16-1:0] REG_MASK = DEF_MASK,
    parameter logic [NREG*4-1:0] REG_WS = DEF_WS,
    parameter logic [NREG-1:0] REG_CONTEND = DEF_CONTEND,
    parameter logic [NREG-1:0] REG_RO = DEF_RO,
    parameter int CONT_TIMEOUT = DEF_TIMEOUT
) (
    input logic  clk,
    input logic  reset_n,
    ace_bus_if.slave bus
);

    state_t           state;
    logic [2:0]       idx;
    logic             hit_q;
    logic             armed;
    logic [CNT_W-1:0] cont_cnt;
    logic [CNT_W-1:0] cont_nxt;
    logic [3:0]       ws_cnt;
    logic [3:0]       p_ws;
    logic [NREG-1:0]  ce_q;
    logic [NREG-1:0]  p_ce;
    logic             we_q;
    logic             p_we;
    logic             wait_q;
    logic             to_q;
    logic [2:0]       dec_idx;
    logic [2:0]       p_idx;
    logic             dec_hit;
    logic             p_hit;
    logic             strobe;
    logic             go_cont;
    logic             cont_to;
    logic             cont_exit;
    logic             enter_post;

    ace_region_decode #(
        .NREG     (NREG),
        .REG_BASE (REG_BASE),
        .REG_MASK (REG_MASK)
    ) u_dec (
        .addr (bus.cpu_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    assign strobe   = is_strobe(bus.mreq_n, bus.rd_n, bus.wr_n);
    assign go_cont  = dec_hit && REG_CONTEND[dec_idx] && bus.video_active;
    assign cont_nxt = cont_cnt + 1'b1;
    assign cont_to  = bus.video_active && (cont_nxt == CNT_W'(CONT_TIMEOUT));
    assign cont_exit = !bus.video_active || cont_to;

    // Region attributes for the access about to leave IDLE/CONTEND.
    assign p_idx = (state == IDLE) ? dec_idx : idx;
    assign p_hit = (state == IDLE) ? dec_hit : hit_q;
    assign p_ws  = p_hit ? REG_WS[{p_idx, 2'b00} +: 4] : 4'd0;
    assign p_we  = p_hit && !bus.wr_n && !REG_RO[p_idx];
    assign p_ce  = p_hit ? (NREG'(1) << p_idx) : '0;

    assign enter_post =
        (state == IDLE && armed && strobe && !go_cont) ||
        (state == CONTEND && !bus.mreq_n && cont_exit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= 3'd0;
            hit_q    <= 1'b0;
            armed    <= 1'b0;
            cont_cnt <= '0;
            ws_cnt   <= 4'd0;
            ce_q     <= '0;
            we_q     <= 1'b0;
            wait_q   <= 1'b1;
            to_q     <= 1'b0;
        end else begin
            // A new access needs mreq_n seen high since reset.
            armed <= armed | bus.mreq_n;
            unique case (state)
                IDLE: begin
                    if (armed && strobe) begin
                        idx      <= dec_idx;
                        hit_q    <= dec_hit;
                        cont_cnt <= '0;
                        if (go_cont) begin
                            state  <= CONTEND;
                            wait_q <= 1'b0;
                        end
                    end
                end
                CONTEND: begin
                    if (bus.mreq_n) begin
                        state  <= IDLE;
                        wait_q <= 1'b1;
                    end else begin
                        cont_cnt <= cont_nxt;
                        if (cont_to) to_q <= 1'b1;
                    end
                end
                WSTATE: begin
                    if (bus.mreq_n) begin
                        state  <= IDLE;
                        wait_q <= 1'b1;
                    end else if (ws_cnt == 4'd1) begin
                        state  <= ACTIVE;
                        wait_q <= 1'b1;
                        ce_q   <= p_ce;
                        we_q   <= p_we;
                    end else begin
                        ws_cnt <= ws_cnt - 4'd1;
                    end
                end
                ACTIVE: begin
                    if (bus.mreq_n) begin
                        state <= IDLE;
                        ce_q  <= '0;
                        we_q  <= 1'b0;
                    end else begin
                        we_q <= p_we;
                    end
                end
            endcase
            if (enter_post) begin
                if (p_ws != 4'd0) begin
                    state  <= WSTATE;
                    ws_cnt <= p_ws;
                    wait_q <= 1'b0;
                end else begin
                    state  <= ACTIVE;
                    wait_q <= 1'b1;
                    ce_q   <= p_ce;
                    we_q   <= p_we;
                end
            end
        end
    end

    assign bus.region_ce    = ce_q;
    assign bus.mem_we       = we_q;
    assign bus.wait_n       = wait_q;
    assign bus.sel_idx      = idx;
    assign bus.hit          = hit_q;
    assign bus.timeout_flag = to_q;
    assign bus.data_to_cpu  =
        (state == ACTIVE && hit_q && !bus.rd_n) ?
        bus.region_dout[{idx, 3'b000} +: 8] : 8'hFF;

endmodule

// File: doc/ace_bus_ctrl.md
ACE_BUS_CTRL -- requirements
Module: ace_bus_ctrl

Interface
REQ-001 Parameter NREG, 6, number of decoded memory regions (1..8).
REQ-002 Parameter REG_BASE, {16'h8000,16'h4000,16'h3C00,16'h2C00,16'h2400,16'h0000}, packed per-region base address (region 0 in LSBs).
REQ-003 Parameter REG_MASK, {16'h8000,16'hC000,16'hFC00,16'hFC00,16'hFC00,16'hE000}, packed per-region compare mask.
REQ-004 Parameter REG_WS, {4'd2,4'd1,4'd0,4'd0,4'd0,4'd0}, packed per-region fixed wait states (0..15).
REQ-005 Parameter REG_CONTEND, 6'b000110, per-region flag: region shared with video fetch.
REQ-006 Parameter REG_RO, 6'b000001, per-region flag: writes suppressed.
REQ-007 Parameter CONT_TIMEOUT, 1023, maximum contention cycles before forced grant (10-bit).
REQ-008 clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-009 reset_n  input  1  asynchronous, active-low reset.
REQ-010 cpu_addr  input  16  CPU address bus.
REQ-011 mreq_n / rd_n / wr_n  input  1 each  CPU memory strobes, active-low.
REQ-012 video_active  input  1  high while video generator owns contended RAM ports.
REQ-013 region_dout  input  NREG*8  packed read data, region i at bits [8i+7:8i].
REQ-014 region_ce  output  NREG  one-hot region chip enable.
REQ-015 mem_we  output  1  write strobe to the selected region.
REQ-016 data_to_cpu  output  8  read data to CPU.
REQ-017 wait_n  output  1  CPU wait request, active-low.
REQ-018 sel_idx  output  3  index of the latched region; hit  output  1  latched access mapped.
REQ-019 timeout_flag  output  1  sticky: a contention timeout has occurred.

Function
REQ-020 Decode: region i matches when (cpu_addr & REG_MASK[i]) == REG_BASE[i]; lowest matching index wins.
REQ-021 FSM states IDLE, CONTEND, WSTATE, ACTIVE.
REQ-022 IDLE: on first clk with mreq_n=0 and (rd_n=0 or wr_n=0), latch index and hit; next state CONTEND if hit and REG_CONTEND[idx] and video_active, else WSTATE if REG_WS[idx]>0, else ACTIVE.
REQ-023 wait_n is registered; low in every cycle the FSM is in CONTEND or WSTATE, high otherwise.
REQ-024 CONTEND: 10-bit counter increments each cycle; exit to WSTATE/ACTIVE (per REQ-022 rule) when video_active=0 or counter reaches CONT_TIMEOUT; timeout exit sets timeout_flag.
REQ-025 WSTATE: down-counter loaded with REG_WS[idx]; wait_n low for exactly REG_WS[idx] cycles, then ACTIVE.
REQ-026 ACTIVE: region_ce[idx]=1 (if hit); mem_we=1 when wr_n=0 and REG_RO[idx]=0; remain until mreq_n=1, then IDLE in the next cycle.
REQ-027 region_ce and mem_we are zero in IDLE, CONTEND and WSTATE.
REQ-028 data_to_cpu = region_dout[idx] in ACTIVE with hit and rd_n=0; 8'hFF otherwise (unmapped, write, or not ACTIVE).
REQ-029 Unmapped access (hit=0): no wait states, no ce, reads return 8'hFF.
REQ-030 mreq_n rising in CONTEND or WSTATE (aborted cycle): return to IDLE next cycle, no ce or we issued.
REQ-031 video_active changes after the IDLE decision are ignored for that access.
REQ-032 Address is decoded only in IDLE; cpu_addr changes mid-access do not alter idx.

Reset
REQ-033 reset_n=0 forces immediately: state IDLE, counters 0, region_ce=0, mem_we=0, wait_n=1, sel_idx=0, hit=0, timeout_flag=0, data_to_cpu=8'hFF.
REQ-034 Reset asserted mid-access aborts it; no strobe reissued after release until a fresh mreq_n low.

Structure
REQ-035 Package ace_bus_pkg holds the FSM state type, default region map constants and the timeout-counter width.
REQ-036 Combinational priority decoder is sub-module ace_region_decode (addr in, hit and index out), instanced once.

Verification
REQ-037 Read 0x0100, region0 dout 8'h3E -> no wait, region_ce=6'b000001 one cycle after strobe, data_to_cpu=8'h3E.
REQ-038 Write 0x0100 (RO) -> region_ce[0]=1, mem_we stays 0.
REQ-039 Read 0x2400 with video_active high for 20 cycles -> wait_n low 20 cycles, then region_ce[1]=1, timeout_flag=0.
REQ-040 Read 0x2C00, video_active held high, CONT_TIMEOUT=1023 -> wait_n released after 1023 cycles, timeout_flag=1 until reset.
REQ-041 Read 0x8000 -> wait_n low exactly 2 cycles, then region_ce[5]=1; read 0x2000 with REG_MASK[0] changed to 16'hF000 -> hit=0, data_to_cpu=8'hFF, no wait.
REQ-042 reset_n pulsed low during WSTATE of 0x8000 read -> all outputs to REQ-033 values within the same cycle; next access decoded normally.
